// File: rtl/servo_pkg.sv
// Shared servo definitions: duty width, frame/tick derivation used by both the
// servo output path and the PWM decoder, and the decoder state encoding.
package servo_pkg;

    localparam int DUTY_W = 10;

    typedef enum logic [1:0] {
        SYNC,
        WAIT_RISE,
        HIGH,
        LOW
    } dec_state_t;

    function automatic int frame_cyc(input int period_ns, input int clk_mhz);
        return period_ns * clk_mhz / 1000;
    endfunction

    // One duty unit is 1/1024 of a frame, rounded down to whole clocks.
    function automatic int tick_cyc(input int period_ns, input int clk_mhz);
        return frame_cyc(period_ns, clk_mhz) / (1 << DUTY_W);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Input conditioning for the PWM line: 2-flop synchronizer, optional 3-sample
// majority filter (PWM_DECODER_FILTER_EN), registered rise/fall strobes.
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic ready
);

`ifdef PWM_DECODER_FILTER_EN
    localparam int FILL_W = 6;
`else
    localparam int FILL_W = 3;
`endif

    logic [1:0]        sync_q;
    logic              s;
    logic              s_d;
    logic [FILL_W-1:0] fill;

`ifdef PWM_DECODER_FILTER_EN
    logic [1:0] hist;
    logic       filt;

    always_ff @(posedge clk) begin
        if (reset) begin
            hist <= '0;
            filt <= 1'b0;
        end else begin
            hist <= {hist[0], sync_q[1]};
            filt <= (sync_q[1] & hist[0]) | (sync_q[1] & hist[1]) | (hist[0] & hist[1]);
        end
    end

    assign s = filt;
`else
    assign s = sync_q[1];
`endif

    // The pipeline is zeroed by reset, so strobes are held off until it has
    // refilled with real samples; otherwise a line already high would look
    // like a fresh rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            s_d    <= 1'b0;
            fill   <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            s_d    <= s;
            fill   <= {fill[FILL_W-2:0], 1'b1};
            rise   <= fill[FILL_W-1] & s & ~s_d;
            fall   <= fill[FILL_W-1] & ~s & s_d;
        end
    end

    assign level = s_d;
    assign ready = fill[FILL_W-1];

endmodule

// File: rtl/pwm_decoder.sv
// PWM pulse-width decoder reporting high time on the 10-bit servo duty scale,
// with period-error and loss-of-signal flags. Optional input filter: PWM_DECODER_FILTER_EN.
module pwm_decoder
    import servo_pkg::*;
#(
    parameter int PERIOD_NS      = 20000000,
    parameter int CLK_MHZ        = 50,
    parameter int TIMEOUT_FRAMES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_out,
    output logic              duty_valid,
    output logic              period_err,
    output logic              timeout
);

    localparam int FRAME_CYC = frame_cyc(PERIOD_NS, CLK_MHZ);
    localparam int TICK_CYC  = tick_cyc(PERIOD_NS, CLK_MHZ);
    localparam int FRAME_W   = $clog2(FRAME_CYC * (TIMEOUT_FRAMES + 1));
    localparam int PRE_W     = $clog2(TICK_CYC + 1);

    localparam logic [FRAME_W-1:0] TO_LAST  = FRAME_W'(TIMEOUT_FRAMES * FRAME_CYC - 1);
    localparam logic [FRAME_W-1:0] LEN_MIN  = FRAME_W'(FRAME_CYC * 3 / 4);
    localparam logic [FRAME_W-1:0] LEN_MAX  = FRAME_W'(FRAME_CYC * 5 / 4);
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(TICK_CYC - 1);

    logic level, rise, fall, ready, any_edge;

    edge_sync u_edge_sync (
        .clk   (clk),
        .reset (reset),
        .raw   (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall),
        .ready (ready)
    );

    assign any_edge = rise | fall;

    dec_state_t        state, state_next;
    logic [PRE_W-1:0]   presc;
    logic [DUTY_W-1:0]  tick_cnt, tick_now;
    logic [FRAME_W-1:0] frame_cnt, frame_len, idle_cnt;
    logic               clr_cnt, run_cnt, load_duty, eval_period, to_hit, wrap;

    // tick_now includes the current cycle, so a falling edge reports floor(high/TICK_CYC).
    assign wrap      = (presc == PRE_LAST);
    assign tick_now  = (wrap && tick_cnt != '1) ? tick_cnt + 1'b1 : tick_cnt;
    assign frame_len = (frame_cnt == '1) ? frame_cnt : frame_cnt + 1'b1;
    assign to_hit    = (idle_cnt == TO_LAST) && !any_edge;

    always_ff @(posedge clk) begin
        if (reset) state <= SYNC;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        clr_cnt     = 1'b0;
        run_cnt     = 1'b0;
        load_duty   = 1'b0;
        eval_period = 1'b0;
        case (state)
            SYNC:      if (ready && !level) state_next = WAIT_RISE;
            WAIT_RISE: if (rise) begin
                           clr_cnt    = 1'b1;
                           state_next = HIGH;
                       end
            HIGH:      begin
                           run_cnt = 1'b1;
                           if (fall) begin
                               load_duty  = 1'b1;
                               state_next = LOW;
                           end
                       end
            LOW:       begin
                           run_cnt = 1'b1;
                           if (rise) begin
                               eval_period = 1'b1;
                               clr_cnt     = 1'b1;
                               state_next  = HIGH;
                           end
                       end
            default:   state_next = SYNC;
        endcase
        if (to_hit) state_next = SYNC;
    end

    // duty_valid is a one-cycle strobe with no back-pressure; duty_out is
    // stable from that strobe until the next one and survives timeouts.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc      <= '0;
            tick_cnt   <= '0;
            frame_cnt  <= '0;
            idle_cnt   <= '0;
            duty_out   <= '0;
            duty_valid <= 1'b0;
            period_err <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            duty_valid <= load_duty;
            if (clr_cnt) begin
                presc     <= '0;
                tick_cnt  <= '0;
                frame_cnt <= '0;
            end else if (run_cnt) begin
                presc     <= wrap ? '0 : presc + 1'b1;
                tick_cnt  <= tick_now;
                frame_cnt <= frame_len;
            end
            if (load_duty) duty_out <= tick_now;
            if (eval_period && (frame_len < LEN_MIN || frame_len > LEN_MAX)) period_err <= 1'b1;
            if (any_edge)            idle_cnt <= '0;
            else if (idle_cnt != '1) idle_cnt <= idle_cnt + 1'b1;
            if (rise)        timeout <= 1'b0;
            else if (to_hit) timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder on a shortened frame (3072 clocks, 3 clocks per duty unit).
module tb_pwm_decoder;

    localparam int PERIOD_NS      = 61440;
    localparam int CLK_MHZ        = 50;
    localparam int TIMEOUT_FRAMES = 2;
    localparam int FRAME          = 3072;
    localparam int TO_CYC         = 6144;
`ifdef PWM_DECODER_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       pwm_in;
    logic [9:0] duty_out;
    logic       duty_valid;
    logic       period_err;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int valid_cnt = 0;
    int valid_cyc = 0;
    int rise_n   = 0;
    int fall_n   = 0;
    logic [9:0] last_duty = '0;

    pwm_decoder #(
        .PERIOD_NS      (PERIOD_NS),
        .CLK_MHZ        (CLK_MHZ),
        .TIMEOUT_FRAMES (TIMEOUT_FRAMES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .duty_out   (duty_out),
        .duty_valid (duty_valid),
        .period_err (period_err),
        .timeout    (timeout)
    );

    // clock / cycle numbering: after posedge k, cyc == k
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // strobe recorder
    always @(negedge clk) begin
        if (duty_valid) begin
            valid_cnt = valid_cnt + 1;
            last_duty = duty_out;
            valid_cyc = cyc;
        end
    end

    // driver: one frame, inputs change just after a negedge; g1/g2 place
    // single-cycle glitches at those low-phase offsets (0 = none)
    task automatic frame(input int high, input int period, input int g1, input int g2);
        pwm_in = 1'b1;
        rise_n = cyc + 1;
        repeat (high) @(negedge clk);
        pwm_in = 1'b0;
        fall_n = cyc + 1;
        for (int i = 0; i < period - high; i++) begin
            pwm_in = (i != 0) && (i == g1 || i == g2);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (duty_out !== 10'd0) begin n_fail++; $display("FAIL reset_duty_out: got %0d expected 0", duty_out); end
        n_checks++; if (duty_valid !== 1'b0) begin n_fail++; $display("FAIL reset_duty_valid: got %b expected 0", duty_valid); end
        n_checks++; if (period_err !== 1'b0) begin n_fail++; $display("FAIL reset_period_err: got %b expected 0", period_err); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        reset = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_nominal();
        int c0;
        for (int i = 0; i < 3; i++) begin
            c0 = valid_cnt;
            frame(85, FRAME, 0, 0);
            n_checks++; if (valid_cnt - c0 !== 1) begin n_fail++; $display("FAIL nominal_strobes[%0d]: got %0d expected 1", i, valid_cnt - c0); end
            n_checks++; if (last_duty !== 10'd28) begin n_fail++; $display("FAIL nominal_duty[%0d]: got %0d expected 28", i, last_duty); end
            n_checks++; if (valid_cyc !== fall_n + LAT) begin n_fail++; $display("FAIL nominal_latency[%0d]: got cycle %0d expected %0d", i, valid_cyc, fall_n + LAT); end
        end
        n_checks++; if (period_err !== 1'b0) begin n_fail++; $display("FAIL nominal_period_err: got %b expected 0", period_err); end
    endtask

    task automatic test_duty_values();
        int hi[5] = '{150, 20, 4, 3, 2};
        int ex[5] = '{50, 6, 1, 1, 0};
        int c0;
        for (int i = 0; i < 5; i++) begin
            c0 = valid_cnt;
            frame(hi[i], FRAME, 0, 0);
            n_checks++; if (valid_cnt - c0 !== 1) begin n_fail++; $display("FAIL duty_strobes[high=%0d]: got %0d expected 1", hi[i], valid_cnt - c0); end
            n_checks++; if (int'(last_duty) !== ex[i]) begin n_fail++; $display("FAIL duty_value[high=%0d]: got %0d expected %0d", hi[i], last_duty, ex[i]); end
        end
    endtask

    task automatic test_timeout();
        int e;
        int c0;
        frame(150, FRAME, 0, 0);
        e = fall_n + LAT;
        while (cyc < e + TO_CYC - 1) @(negedge clk);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0 at cycle %0d", timeout, cyc); end
        @(negedge clk);
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_threshold: got %b expected 1 at cycle %0d", timeout, cyc); end
        n_checks++; if (duty_out !== 10'd50) begin n_fail++; $display("FAIL timeout_duty_hold: got %0d expected 50", duty_out); end
        repeat (200) @(negedge clk);
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_level: got %b expected 1", timeout); end
        c0 = valid_cnt;
        frame(85, FRAME, 0, 0);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b expected 0", timeout); end
        n_checks++; if (valid_cnt - c0 !== 1) begin n_fail++; $display("FAIL recovery_strobes: got %0d expected 1", valid_cnt - c0); end
        n_checks++; if (last_duty !== 10'd28) begin n_fail++; $display("FAIL recovery_duty: got %0d expected 28", last_duty); end
        n_checks++; if (period_err !== 1'b0) begin n_fail++; $display("FAIL recovery_period_err: got %b expected 0", period_err); end
    endtask

    task automatic test_period_err();
        frame(85, FRAME, 0, 0);
        n_checks++; if (period_err !== 1'b0) begin n_fail++; $display("FAIL perr_nominal: got %b expected 0", period_err); end
        frame(85, 2100, 0, 0);
        n_checks++; if (period_err !== 1'b0) begin n_fail++; $display("FAIL perr_before_close: got %b expected 0", period_err); end
        frame(85, FRAME, 0, 0);
        n_checks++; if (period_err !== 1'b1) begin n_fail++; $display("FAIL perr_short_frame: got %b expected 1", period_err); end
        frame(85, FRAME, 0, 0);
        n_checks++; if (period_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b expected 1", period_err); end
        n_checks++; if (last_duty !== 10'd28) begin n_fail++; $display("FAIL perr_duty: got %0d expected 28", last_duty); end
    endtask

    task automatic test_glitch();
        int c0;
        int exp_cnt;
        logic [9:0] exp_duty;
`ifdef PWM_DECODER_FILTER_EN
        exp_cnt  = 1;
        exp_duty = 10'd28;
`else
        exp_cnt  = 3;
        exp_duty = 10'd0;
`endif
        c0 = valid_cnt;
        frame(85, FRAME, 500, 1500);
        n_checks++; if (valid_cnt - c0 !== exp_cnt) begin n_fail++; $display("FAIL glitch_strobes: got %0d expected %0d", valid_cnt - c0, exp_cnt); end
        n_checks++; if (last_duty !== exp_duty) begin n_fail++; $display("FAIL glitch_duty: got %0d expected %0d", last_duty, exp_duty); end
    endtask

    task automatic test_reset_mid_pulse();
        int c0;
        pwm_in = 1'b1;
        repeat (50) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (duty_out !== 10'd0) begin n_fail++; $display("FAIL midreset_duty_out: got %0d expected 0", duty_out); end
        n_checks++; if (period_err !== 1'b0) begin n_fail++; $display("FAIL midreset_period_err: got %b expected 0", period_err); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL midreset_timeout: got %b expected 0", timeout); end
        reset = 1'b0;
        c0 = valid_cnt;
        repeat (200) @(negedge clk);
        pwm_in = 1'b0;
        repeat (300) @(negedge clk);
        n_checks++; if (valid_cnt !== c0) begin n_fail++; $display("FAIL midreset_partial_pulse: got %0d strobes expected 0", valid_cnt - c0); end
        frame(85, FRAME, 0, 0);
        n_checks++; if (valid_cnt - c0 !== 1) begin n_fail++; $display("FAIL midreset_strobes: got %0d expected 1", valid_cnt - c0); end
        n_checks++; if (last_duty !== 10'd28) begin n_fail++; $display("FAIL midreset_duty: got %0d expected 28", last_duty); end
        n_checks++; if (valid_cyc !== fall_n + LAT) begin n_fail++; $display("FAIL midreset_latency: got cycle %0d expected %0d", valid_cyc, fall_n + LAT); end
    endtask

    initial begin
        reset  = 1'b1;
        pwm_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_duty_values();
        test_timeout();
        test_period_err();
        test_glitch();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
